// File: rtl/tsc_multi.sv
// Multi-channel PPS timestamp counter: free-running TSC, local second counter,
// per-channel phase/period error capture, loss detection and one-shot resync.
module tsc_multi #(
    parameter int CLK_FREQ = 100000000,
    parameter int CNT_W    = 64,
    parameter int N_CH     = 2,
    parameter int DIFF_W   = 32,
    parameter int SYNC_OFS = 2,
    parameter int LOST_CYC = CLK_FREQ + CLK_FREQ/16,
    localparam int SEC_W   = $clog2(CLK_FREQ),
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          pps_in,
    input  logic                     tsc_read,
    input  logic                     resync_req,
    input  logic [CH_W-1:0]          resync_ch,
    output logic [CNT_W-1:0]         tsc_cnt,
    output logic [CNT_W-1:0]         tsc_cnt_lat,
    output logic [SEC_W-1:0]         sec_cnt,
    output logic                     tsc_1pps,
    output logic [N_CH*DIFF_W-1:0]   pdiff,
    output logic [N_CH*DIFF_W-1:0]   fdiff,
    output logic [N_CH-1:0]          diff_vld,
    output logic [N_CH-1:0]          fdiff_vld,
    output logic [N_CH-1:0]          pps_lost,
    output logic                     sync_busy,
    output logic                     sync_done,
    output logic                     sync_timeout
);

    localparam int HALF = CLK_FREQ / 2;
    localparam int PW   = (DIFF_W > SEC_W + 2) ? DIFF_W : SEC_W + 2;
    localparam int FW   = ((DIFF_W > CNT_W) ? DIFF_W : CNT_W) + 1;
    localparam int GW   = $clog2(LOST_CYC + 1);
    localparam int TW   = $clog2(2*CLK_FREQ + 1);
    localparam int EW   = 1 << CH_W;

    typedef enum logic {IDLE, ARMED} state_t;

    state_t                 state, state_nx;
    logic [N_CH-1:0]        pps_prev, edge_det, have_prev;
    logic [EW-1:0]          edge_ext;
    logic [GW-1:0]          gap [N_CH];
    logic [CNT_W-1:0]       last_ts [N_CH];
    logic [CNT_W-1:0]       period [N_CH];
    logic [DIFF_W-1:0]      fd_val [N_CH];
    logic signed [PW-1:0]   phase;
    logic [CH_W-1:0]        ch_lat;
    logic [TW-1:0]          tmo_cnt;
    logic                   wrap, arm, sync_hit, tmo_hit;

    // Previous sample resets high so an input already high at reset is not an edge.
    assign edge_det = pps_in & ~pps_prev;
    assign edge_ext = EW'(edge_det);
    assign wrap     = (sec_cnt == SEC_W'(CLK_FREQ - 1));

    always_comb begin
        phase = PW'(sec_cnt);
        if (sec_cnt >= SEC_W'(HALF))
            phase = phase - PW'(CLK_FREQ);
    end

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            period[i] = tsc_cnt - last_ts[i];
            fd_val[i] = DIFF_W'({{(FW-CNT_W){1'b0}}, period[i]} - FW'(CLK_FREQ));
        end
    end

    // A resync load overrides the natural wrap; tsc_cnt is never touched by it.
    always_ff @(posedge clk) begin
        if (rst) begin
            tsc_cnt     <= '0;
            tsc_cnt_lat <= '0;
            sec_cnt     <= '0;
            tsc_1pps    <= 1'b0;
        end else begin
            tsc_cnt <= tsc_cnt + CNT_W'(1);
            if (tsc_read)
                tsc_cnt_lat <= tsc_cnt;
            if (sync_hit) begin
                sec_cnt  <= SEC_W'(SYNC_OFS);
                tsc_1pps <= wrap && (SYNC_OFS == 0);
            end else begin
                sec_cnt  <= wrap ? '0 : sec_cnt + SEC_W'(1);
                tsc_1pps <= wrap;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pps_prev  <= '1;
            have_prev <= '0;
            pps_lost  <= '0;
            diff_vld  <= '0;
            fdiff_vld <= '0;
            pdiff     <= '0;
            fdiff     <= '0;
            for (int i = 0; i < N_CH; i++) begin
                gap[i]     <= '0;
                last_ts[i] <= '0;
            end
        end else begin
            pps_prev  <= pps_in;
            diff_vld  <= edge_det;
            fdiff_vld <= edge_det & have_prev & ~pps_lost;
            for (int i = 0; i < N_CH; i++) begin
                if (edge_det[i]) begin
                    pdiff[i*DIFF_W +: DIFF_W] <= phase[DIFF_W-1:0];
                    fdiff[i*DIFF_W +: DIFF_W] <= fd_val[i];
                    last_ts[i]   <= tsc_cnt;
                    have_prev[i] <= 1'b1;
                    gap[i]       <= '0;
                    pps_lost[i]  <= 1'b0;
                end else begin
                    if (gap[i] != GW'(LOST_CYC))
                        gap[i] <= gap[i] + GW'(1);
                    if (gap[i] >= GW'(LOST_CYC - 1))
                        pps_lost[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (resync_req) state_nx = ARMED;
            ARMED:   if (sync_hit || tmo_hit) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        sync_busy = (state == ARMED);
        arm       = (state == IDLE) && resync_req;
        sync_hit  = (state == ARMED) && edge_ext[ch_lat];
        tmo_hit   = (state == ARMED) && !edge_ext[ch_lat] &&
                    (tmo_cnt == TW'(2*CLK_FREQ - 1));
    end

    // tmo_cnt counts cycles spent in ARMED; pulses are registered one cycle late.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_lat       <= '0;
            tmo_cnt      <= '0;
            sync_done    <= 1'b0;
            sync_timeout <= 1'b0;
        end else begin
            if (arm)
                ch_lat <= resync_ch;
            tmo_cnt      <= (state == ARMED) ? tmo_cnt + TW'(1) : '0;
            sync_done    <= sync_hit;
            sync_timeout <= tmo_hit;
        end
    end

endmodule

// File: doc/tsc_multi.md
TSC_MULTI -- requirements
Module: tsc_multi

Interface
REQ-001 Parameter CLK_FREQ, default 100000000, clk cycles per second (>= 8).
REQ-002 Parameter CNT_W, default 64, tsc_cnt width.
REQ-003 Parameter N_CH, default 2, number of PPS capture channels (1..8).
REQ-004 Parameter DIFF_W, default 32, signed width of pdiff/fdiff.
REQ-005 Parameter SYNC_OFS, default 2, sec_cnt load value on resync (0..CLK_FREQ-1).
REQ-006 Parameter LOST_CYC, default CLK_FREQ+CLK_FREQ/16, edge-free cycles before a channel is declared lost.
REQ-007 clk  in  1  single clock, all logic rising-edge.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 pps_in  in  N_CH  per-channel PPS, already synchronous to clk.
REQ-010 tsc_read  in  1  snapshot request pulse.
REQ-011 resync_req  in  1  one-cycle pulse, arm resync.
REQ-012 resync_ch  in  $clog2(N_CH) (min 1)  channel used for resync.
REQ-013 tsc_cnt  out  CNT_W  free-running cycle counter.
REQ-014 tsc_cnt_lat  out  CNT_W  tsc_cnt captured by tsc_read.
REQ-015 sec_cnt  out  $clog2(CLK_FREQ)  sub-second counter.
REQ-016 tsc_1pps  out  1  one-cycle local second pulse.
REQ-017 pdiff  out  N_CH*DIFF_W  signed phase error, channel i at bits [i*DIFF_W +: DIFF_W].
REQ-018 fdiff  out  N_CH*DIFF_W  signed period error, same packing.
REQ-019 diff_vld / fdiff_vld / pps_lost  out  N_CH each  per-channel pdiff-valid pulse, fdiff-valid pulse, lost flag.
REQ-020 sync_busy / sync_done / sync_timeout  out  1 each  resync FSM level, success pulse, timeout pulse.

Function
REQ-021 tsc_cnt SHALL increment by 1 every cycle, wrapping 2^CNT_W-1 -> 0.
REQ-022 sec_cnt SHALL count 0..CLK_FREQ-1 and wrap to 0; tsc_1pps SHALL be 1 exactly in cycles where sec_cnt==0 due to a wrap (never the first cycle after reset).
REQ-023 tsc_read=1 in cycle T SHALL make tsc_cnt_lat equal tsc_cnt(T) from T+1; value held otherwise.
REQ-024 Edge on channel i: pps_in[i]=1 in cycle T and 0 in T-1 (reset-time previous sample = 1, so a high input at reset is not an edge).
REQ-025 On edge at T with phase p=sec_cnt(T): pdiff_i = p if p < CLK_FREQ/2, else p-CLK_FREQ, sign-extended/truncated to DIFF_W; valid from T+1 with diff_vld[i]=1 for cycle T+1 only.
REQ-026 fdiff_i = ((tsc_cnt(T) - tsc_cnt(previous edge)) mod 2^CNT_W) - CLK_FREQ, low DIFF_W bits; fdiff_vld[i] pulses at T+1 only if a previous edge exists and pps_lost[i] was 0 at T.
REQ-027 Per-channel gap counter SHALL clear on each edge; pps_lost[i] SHALL set when it reaches LOST_CYC and clear at T+1 of the next edge; counter saturates.
REQ-028 Resync FSM states IDLE, ARMED; IDLE--resync_req-->ARMED (resync_ch latched, sync_busy=1); resync_req while ARMED is ignored.
REQ-029 ARMED, edge on latched channel at T: sec_cnt(T+1)=SYNC_OFS, sync_done=1 at T+1, return IDLE; that edge's pdiff reports pre-load phase.
REQ-030 ARMED with no edge for 2*CLK_FREQ cycles: sync_timeout=1 one cycle, return IDLE, sec_cnt untouched.
REQ-031 Resync load coinciding with a natural wrap: load wins; tsc_1pps=1 in that next cycle only if SYNC_OFS==0.
REQ-032 tsc_cnt SHALL NOT be altered by resync.
REQ-033 Channels SHALL be fully independent; simultaneous edges on all channels all report in the same cycle.

Reset
REQ-034 rst=1 at a clk edge SHALL zero tsc_cnt, tsc_cnt_lat, sec_cnt, pdiff, fdiff, gap counters, all pulses; pps_lost=0; FSM=IDLE; previous-edge-valid flags cleared; reset mid-ARMED aborts without sync_done/sync_timeout.

Verification (CLK_FREQ=1000, SYNC_OFS=2, LOST_CYC=1062, N_CH=2)
REQ-035 Release reset, idle -> first tsc_1pps at cycle 1000, then every 1000; tsc_cnt=1000 at first pulse.
REQ-036 Ch0 edges at sec_cnt=10, then exactly 1000 cycles later -> pdiff=+10, second edge fdiff=0 with fdiff_vld; first edge has diff_vld only.
REQ-037 Ch1 edges at sec_cnt=990 with 998-cycle spacing -> pdiff=-10, then -12; fdiff=-2.
REQ-038 Stop ch0 for 1062 cycles -> pps_lost[0]=1; next edge clears it, fdiff_vld[0]=0 on that edge.
REQ-039 resync_req ch1, edge at sec_cnt=500 -> pdiff=+500, sec_cnt=2 next cycle, sync_done pulse, tsc_1pps 998 cycles later; tsc_cnt continuous.
REQ-040 resync_req with no edges -> sync_timeout after 2000 cycles; rst asserted mid-ARMED -> no pulses, sync_busy=0.
